// File: rtl/avs_ps2_ctrl_if.sv
// Avalon-MM slave bus and PS/2 pin bundle for avs_ps2_ctrl.
// The pins are open-drain: *_oe = 1 pulls the line low, and *_i is the wired line level.
interface avs_ps2_ctrl_if;
    logic [1:0]  avs_s0_address;
    logic        avs_s0_read;
    logic        avs_s0_write;
    logic        avs_s0_waitrequest;
    logic [31:0] avs_s0_readdata;
    logic [31:0] avs_s0_writedata;
    logic        avs_s0_irq;
    logic        avs_s0_export_ps2_clk_i;
    logic        avs_s0_export_ps2_data_i;
    logic        avs_s0_export_ps2_clk_oe;
    logic        avs_s0_export_ps2_data_oe;

    modport slave (
        input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
               avs_s0_export_ps2_clk_i, avs_s0_export_ps2_data_i,
        output avs_s0_waitrequest, avs_s0_readdata, avs_s0_irq,
               avs_s0_export_ps2_clk_oe, avs_s0_export_ps2_data_oe
    );

    modport master (
        output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
               avs_s0_export_ps2_clk_i, avs_s0_export_ps2_data_i,
        input  avs_s0_waitrequest, avs_s0_readdata, avs_s0_irq,
               avs_s0_export_ps2_clk_oe, avs_s0_export_ps2_data_oe
    );
endinterface

// File: rtl/avs_ps2_ctrl.sv
// PS/2 host controller with an Avalon-MM slave: RX FIFO, error flags, level irq.
// The host-to-device transmit path is built only when AVS_PS2_TX_EN is defined.
module avs_ps2_ctrl #(
    parameter int FIFO_DEPTH     = 16,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic           clk,
    input logic           reset,
    avs_ps2_ctrl_if.slave s0
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    // clk_s[2] is the previous synced sample, used for edge detection.
    logic [2:0] clk_s;
    logic [1:0] data_s;
    logic       fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s  <= '1;
            data_s <= '1;
        end else begin
            clk_s  <= {clk_s[1:0], s0.avs_s0_export_ps2_clk_i};
            data_s <= {data_s[0], s0.avs_s0_export_ps2_data_i};
        end
    end
    assign fall = clk_s[2] & ~clk_s[1];

    logic        tx_busy, tx_to_active, tx_clk_oe, nack_set, to_fire;
    logic [2:0]  ctrl;
    logic [4:0]  w1c;
    logic        rd_data, pop, empty, full, push, push_ok;
    logic        ovf, par_err, frm_err, tmo, nack;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [7:0]    status;
    logic          unused_wdata;

    assign rd_data = s0.avs_s0_read && s0.avs_s0_address == 2'd0;
    assign w1c     = (s0.avs_s0_write && s0.avs_s0_address == 2'd1) ? s0.avs_s0_writedata[6:2] : 5'd0;
    assign empty   = level == '0;
    assign full    = level == FULL_LVL;
    assign pop     = rd_data & ~empty;
    assign unused_wdata = &{1'b0, s0.avs_s0_writedata[31:7]};

`ifdef AVS_PS2_TX_EN
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [2:0] TX_IDLE    = 3'd0,
                           TX_INHIBIT = 3'd1,
                           TX_REQ     = 3'd2,
                           TX_BITS    = 3'd3,
                           TX_ACK     = 3'd4,
                           TX_WAIT    = 3'd5;
    logic [2:0]    state;
    logic [8:0]    tx_shift;
    logic [3:0]    tx_cnt;
    logic [IW-1:0] inh_cnt;
    logic          data_oe, wr_data;

    assign wr_data      = s0.avs_s0_write && s0.avs_s0_address == 2'd0;
    assign tx_busy      = state != TX_IDLE;
    assign tx_to_active = tx_busy && state != TX_INHIBIT;
    assign tx_clk_oe    = state == TX_INHIBIT;
    assign nack_set     = state == TX_ACK && fall && data_s[1];
    assign s0.avs_s0_waitrequest        = wr_data & tx_busy;
    assign s0.avs_s0_export_ps2_data_oe = data_oe;

    // tx_shift holds {parity, byte}; bit 0 goes out on the next falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= TX_IDLE;
            tx_shift <= '0;
            tx_cnt   <= '0;
            inh_cnt  <= '0;
            data_oe  <= 1'b0;
        end else if (to_fire) begin
            state   <= TX_IDLE;
            data_oe <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: if (wr_data) begin
                    tx_shift <= {~^s0.avs_s0_writedata[7:0], s0.avs_s0_writedata[7:0]};
                    inh_cnt  <= '0;
                    state    <= TX_INHIBIT;
                end
                TX_INHIBIT: if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                    data_oe <= 1'b1;
                    state   <= TX_REQ;
                end else begin
                    inh_cnt <= inh_cnt + 1'b1;
                end
                TX_REQ: begin
                    tx_cnt <= '0;
                    state  <= TX_BITS;
                end
                TX_BITS: if (fall) begin
                    if (tx_cnt == 4'd9) begin
                        data_oe <= 1'b0;
                        state   <= TX_ACK;
                    end else begin
                        data_oe  <= ~tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[8:1]};
                        tx_cnt   <= tx_cnt + 1'b1;
                    end
                end
                TX_ACK:  if (fall) state <= TX_WAIT;
                TX_WAIT: if (clk_s[1] & data_s[1]) state <= TX_IDLE;
                default: state <= TX_IDLE;
            endcase
        end
    end
`else
    assign tx_busy      = 1'b0;
    assign tx_to_active = 1'b0;
    assign tx_clk_oe    = 1'b0;
    assign nack_set     = 1'b0;
    assign s0.avs_s0_waitrequest        = 1'b0;
    assign s0.avs_s0_export_ps2_data_oe = 1'b0;
`endif

    assign s0.avs_s0_export_ps2_clk_oe = tx_clk_oe | (ctrl[2] & ~tx_busy);

    // RX: shift holds the 10 bits before the current one, start bit ends up at [0].
    logic [3:0]  bit_cnt;
    logic [9:0]  shift;
    logic [10:0] frame;
    logic        rx_edge, rx_done, frm_bad, par_bad;

    assign frame   = {data_s[1], shift};
    assign rx_edge = fall & ~tx_busy;
    assign rx_done = rx_edge && bit_cnt == 4'd10;
    assign frm_bad = frame[0] | ~frame[10];
    assign par_bad = ~^frame[9:1];
    assign push    = rx_done & ~frm_bad & ~par_bad;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (to_fire || tx_busy) begin
            bit_cnt <= '0;
        end else if (rx_edge) begin
            shift   <= frame[10:1];
            bit_cnt <= rx_done ? 4'd0 : bit_cnt + 1'b1;
        end
    end

    logic          to_active;
    logic [TW-1:0] to_cnt;

    assign to_active = (bit_cnt != 4'd0) | tx_to_active;
    assign to_fire   = to_active && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           to_cnt <= '0;
        else if (!to_active || fall || to_fire) to_cnt <= '0;
        else                                 to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= frame[8:1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A set event in the same cycle as a W1C write wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf     <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            tmo     <= 1'b0;
            nack    <= 1'b0;
            ctrl    <= '0;
        end else begin
            ovf     <= (push & full & ~pop) | (ovf & ~w1c[0]);
            par_err <= (rx_done & par_bad)  | (par_err & ~w1c[1]);
            frm_err <= (rx_done & frm_bad)  | (frm_err & ~w1c[2]);
            tmo     <= to_fire              | (tmo & ~w1c[3]);
            nack    <= nack_set             | (nack & ~w1c[4]);
            if (s0.avs_s0_write && s0.avs_s0_address == 2'd2) ctrl <= s0.avs_s0_writedata[2:0];
        end
    end

    assign status = {1'b0, nack, tmo, frm_err, par_err, ovf, tx_busy, ~empty};
    assign s0.avs_s0_irq = (ctrl[0] & ~empty) | (ctrl[1] & |status[6:2]);

    always_comb begin
        s0.avs_s0_readdata = '0;
        if (s0.avs_s0_read) begin
            case (s0.avs_s0_address)
                2'd0:    if (!empty) s0.avs_s0_readdata[7:0] = mem[rd_ptr];
                2'd1:    s0.avs_s0_readdata[7:0] = status;
                2'd2:    s0.avs_s0_readdata[2:0] = ctrl;
                default: s0.avs_s0_readdata[AW:0] = level;
            endcase
        end
    end
endmodule

// File: doc/avs_ps2_ctrl.md
# avs_ps2_ctrl

Parametrised PS/2 host controller with an Avalon-MM slave port (`avs_s0`), the next generation of the team's PS/2 slave. It supports device-to-host receive into a configurable FIFO, with parity, framing, timeout and overflow detection, and host-to-device transmit with inhibit/request-to-send sequencing. A level interrupt is provided. It sits on the Avalon interconnect beside the other `avs_*` peripherals and drives the PS/2 pins through open-drain enables.

## Interface
- `FIFO_DEPTH`, 16: RX FIFO entries; power of two, 2..256.
- `INHIBIT_CYCLES`, 5000: `clk` cycles the PS/2 clock is held low before a transmit (≥100 µs).
- `TIMEOUT_CYCLES`, 100000: maximum `clk` cycles between PS/2 clock falling edges inside a frame.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `avs_s0_address`  in  2  register select.
- `avs_s0_read`  in  1  read strobe.
- `avs_s0_write`  in  1  write strobe.
- `avs_s0_waitrequest`  out  1  stalls a data write while transmit is busy.
- `avs_s0_readdata`  out  32  read data; bits [31:8] are 0.
- `avs_s0_writedata`  in  32  write data; only [7:0] is used.
- `avs_s0_irq`  out  1  level interrupt.
- `avs_s0_export_ps2_clk_i`  in  1  PS/2 clock pin input (asynchronous).
- `avs_s0_export_ps2_data_i`  in  1  PS/2 data pin input (asynchronous).
- `avs_s0_export_ps2_clk_oe`  out  1  1 pulls the PS/2 clock low.
- `avs_s0_export_ps2_data_oe`  out  1  1 pulls the PS/2 data low.

## Operation
- Register map:
  - addr 0 DATA. Read returns the FIFO head and pops it; an empty FIFO returns 0x00 with no pop. Write starts a transmit of [7:0].
  - addr 1 STATUS. Bits: [0] RX_AVAIL, [1] TX_BUSY, [2] OVERFLOW, [3] PAR_ERR, [4] FRM_ERR, [5] TIMEOUT, [6] TX_NACK. Bits [6:2] are sticky and write-1-to-clear.
  - addr 2 CONTROL (RW, reset 0). Bits: [0] RX_IRQ_EN, [1] ERR_IRQ_EN, [2] RX_INHIBIT (holds clk_oe=1 while not transmitting).
  - addr 3 LEVEL. Read-only FIFO occupancy.
- Both pins pass through 2-flop synchronisers. A falling edge is synced clk going 1→0.
- RX engine:
  - On each falling edge, shift in the synced data bit. The frame is start, 8 data LSB-first, odd parity, stop (11 bits).
  - After bit 11: if start=0, stop=1 and parity is odd, push the byte. Else set FRM_ERR (bad start/stop) or PAR_ERR (bad parity) and drop the byte.
  - A push into a full FIFO drops the byte and sets OVERFLOW.
  - RX is idle while TX_BUSY. Edges seen then belong to TX.
- Timeout: when the bit counter is nonzero (RX) or the TX FSM is past INHIBIT, the counter is reset on every falling edge. On reaching TIMEOUT_CYCLES, abort the frame, release both OEs, set TIMEOUT and return to idle.
- TX FSM:
  - IDLE: a DATA write latches the byte and computes odd parity → INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES → REQ.
  - REQ: data_oe=1 (start bit), clk_oe=0 → BITS.
  - BITS: on each falling edge, drive the next bit (data_oe = ~bit) for d0..d7 then parity. On the falling edge after parity, data_oe=0 (stop) → ACK.
  - ACK: on the next falling edge, sample data. 1 sets TX_NACK → WAIT_IDLE.
  - WAIT_IDLE: wait for synced clk=1 and data=1 → IDLE.
  - TX_BUSY = state≠IDLE.
- `avs_s0_irq` = (RX_IRQ_EN & RX_AVAIL) | (ERR_IRQ_EN & |STATUS[6:2]).

## Timing
- Reset values: all OEs 0, irq 0, waitrequest 0, readdata 0, FIFO empty, STATUS 0, CONTROL 0, FSMs idle. Reset mid-frame or mid-transmit discards everything and releases the pins immediately (asynchronous).
- Readdata is combinational, with read latency 0. A pop takes effect at the clock edge ending the read.
- Waitrequest is combinational: 1 when write & addr 0 & TX_BUSY. The write completes in the cycle TX_BUSY is 0.
- Push latency: the byte is visible one cycle after the synced stop-bit falling edge is detected (about 3 `clk` cycles after the pin edge).
- Simultaneous push and pop: level is unchanged. If the FIFO is full, the push is accepted and OVERFLOW is not set.
- A W1C write to STATUS in the same cycle as a new error event: the event wins and the bit stays 1.
- Pointers wrap modulo FIFO_DEPTH. LEVEL is clog2(FIFO_DEPTH)+1 bits, zero-extended.

## Configuration
- `AVS_PS2_TX_EN` defined: TX FSM, waitrequest and data_oe logic are present as above.
- Undefined:
  - No TX logic; a DATA write is ignored.
  - waitrequest=0; data_oe=0.
  - clk_oe driven only by RX_INHIBIT.
  - STATUS[1] and [6] read 0.

## Test plan
- Device sends 0x1C with odd parity: LEVEL=1, STATUS[0]=1, DATA read = 0x1C, then LEVEL=0.
- Device sends 0x55 with parity bit inverted: PAR_ERR=1, LEVEL=0. Writing 0x08 to STATUS clears it.
- FIFO_DEPTH+1 frames with no reads: LEVEL=FIFO_DEPTH, OVERFLOW=1, first byte still at head.
- Device stops clocking after 4 bits: TIMEOUT=1 after TIMEOUT_CYCLES. The next full frame is received correctly.
- TX_EN: write 0xFF:
  - clk_oe=1 for INHIBIT_CYCLES, then data_oe=1.
  - Device clocks; wire bits are 0,1×8,parity 1,stop 1. Device ACK 0 gives TX_NACK=0.
  - A second DATA write during transmit sees waitrequest=1 until IDLE.
- RX_IRQ_EN=1 with one byte received: irq=1. Reading DATA drops irq to 0 on the next cycle.
